// File: rtl/tpu_gbuff_host_if.sv
// Host <-> TPU/stream bundle: input word stream, gbuff A/B write ports,
// gbuff O read port, TPU start/done and the result stream.
interface tpu_gbuff_host_if #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              a_wr_en;
  logic [IDX_W-1:0]  a_index;
  logic [DATA_W-1:0] a_data;
  logic              b_wr_en;
  logic [IDX_W-1:0]  b_index;
  logic [DATA_W-1:0] b_data;
  logic [IDX_W-1:0]  o_index;
  logic [DATA_W-1:0] o_rdata;
  logic              tpu_start;
  logic              tpu_done;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  // Both streams: a word moves on a clock edge where valid && ready are high;
  // the producer holds data stable while valid is high and ready is low.
  modport master (
    input  in_valid, in_data, o_rdata, tpu_done, out_ready,
    output in_ready, a_wr_en, a_index, a_data, b_wr_en, b_index, b_data,
           o_index, tpu_start, out_valid, out_data
  );

  modport slave (
    output in_valid, in_data, o_rdata, tpu_done, out_ready,
    input  in_ready, a_wr_en, a_index, a_data, b_wr_en, b_index, b_data,
           o_index, tpu_start, out_valid, out_data
  );
endinterface

// File: rtl/tpu_gbuff_host.sv
// Loads A then B into the TPU global buffers, starts the TPU, then drains gbuff O
// through a 2-entry FIFO. Define TPU_WDOG_EN to add a watchdog on the WAIT state.
module tpu_gbuff_host #(
  parameter int DATA_W   = 32,
  parameter int IDX_W    = 8,
  parameter int WDOG_CYC = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] cfg_m,
  input  logic [3:0] cfg_n,
  input  logic [3:0] cfg_k,
  input  logic       cmd_go,
  output logic       busy,
  output logic       job_done,
  output logic       job_err,
  output logic [2:0] state_dbg,
  tpu_gbuff_host_if.master bus
);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD_A = 3'd1;
  localparam logic [2:0] S_LOAD_B = 3'd2;
  localparam logic [2:0] S_START  = 3'd3;
  localparam logic [2:0] S_WAIT   = 3'd4;
  localparam logic [2:0] S_DRAIN  = 3'd5;
  localparam logic [2:0] S_FIN    = 3'd6;

  function automatic logic [7:0] words(input logic [3:0] d, input logic [3:0] k);
    logic [4:0] s;
    s = {1'b0, d} + 5'd3;
    return {5'd0, s[4:2]} * {4'd0, k};
  endfunction

  logic [2:0]        state;
  logic [7:0]        cnt, na, nb, no, rd_cnt, pop_cnt;
  logic              inflight, wr_ptr, rd_ptr;
  logic [1:0]        fifo_count;
  logic [DATA_W-1:0] fifo_mem [2];
  logic [IDX_W-1:0]  o_index_q;
  logic              in_a, in_b, xfer, pop, issue, wdog_hit;
  logic [2:0]        occ;

  assign in_a          = state == S_LOAD_A;
  assign in_b          = state == S_LOAD_B;
  assign bus.in_ready  = in_a | in_b;
  assign xfer          = bus.in_valid & bus.in_ready;
  assign bus.a_wr_en   = in_a & bus.in_valid;
  assign bus.a_index   = in_a ? IDX_W'(cnt) : '0;
  assign bus.a_data    = bus.a_wr_en ? bus.in_data : '0;
  assign bus.b_wr_en   = in_b & bus.in_valid;
  assign bus.b_index   = in_b ? IDX_W'(cnt) : '0;
  assign bus.b_data    = bus.b_wr_en ? bus.in_data : '0;
  assign bus.tpu_start = state == S_START;
  assign busy          = state != S_IDLE;
  assign job_done      = state == S_FIN;
  assign state_dbg     = state;

  assign bus.out_valid = fifo_count != 2'd0;
  assign bus.out_data  = bus.out_valid ? fifo_mem[rd_ptr] : '0;
  assign pop           = bus.out_valid & bus.out_ready;
  // A pop this cycle frees a slot before any read issued now can land,
  // which is what sustains one word per cycle with the sink always ready.
  assign occ           = {1'b0, fifo_count} + {2'b0, inflight};
  assign issue         = (state == S_DRAIN) && (rd_cnt < no) && (occ < (3'd2 + {2'b0, pop}));
  assign bus.o_index   = issue ? IDX_W'(rd_cnt) : o_index_q;

`ifdef TPU_WDOG_EN
  localparam int WD_W = (WDOG_CYC > 1) ? $clog2(WDOG_CYC) : 1;
  logic [WD_W-1:0] wdog_cnt;
  assign wdog_hit = wdog_cnt == WD_W'(WDOG_CYC - 1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 wdog_cnt <= '0;
    else if (state != S_WAIT) wdog_cnt <= '0;
    else                     wdog_cnt <= wdog_cnt + 1'b1;
  end
`else
  assign wdog_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      na      <= '0;
      nb      <= '0;
      no      <= '0;
      job_err <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (cmd_go) begin
          na  <= words(cfg_m, cfg_k);
          nb  <= words(cfg_n, cfg_k);
          no  <= words(cfg_n, cfg_m);
          cnt <= '0;
          if (cfg_m == 4'd0 || cfg_n == 4'd0 || cfg_k == 4'd0) begin
            job_err <= 1'b1;
            state   <= S_FIN;
          end else begin
            job_err <= 1'b0;
            state   <= S_LOAD_A;
          end
        end
        S_LOAD_A: if (xfer) begin
          if (cnt == na - 8'd1) begin
            cnt   <= '0;
            state <= S_LOAD_B;
          end else cnt <= cnt + 8'd1;
        end
        S_LOAD_B: if (xfer) begin
          if (cnt == nb - 8'd1) begin
            cnt   <= '0;
            state <= S_START;
          end else cnt <= cnt + 8'd1;
        end
        S_START: state <= S_WAIT;
        S_WAIT: begin
          if (bus.tpu_done) state <= S_DRAIN;
          else if (wdog_hit) begin
            job_err <= 1'b1;
            state   <= S_FIN;
          end
        end
        S_DRAIN: if (pop && pop_cnt == no - 8'd1) state <= S_FIN;
        S_FIN:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_cnt      <= '0;
      pop_cnt     <= '0;
      inflight    <= 1'b0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      fifo_count  <= '0;
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      o_index_q   <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        rd_cnt    <= rd_cnt + 8'd1;
        o_index_q <= IDX_W'(rd_cnt);
      end
      if (inflight) begin
        fifo_mem[wr_ptr] <= bus.o_rdata;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr  <= ~rd_ptr;
        pop_cnt <= pop_cnt + 8'd1;
      end
      fifo_count <= fifo_count + {1'b0, inflight} - {1'b0, pop};
      if (state == S_IDLE) begin
        rd_cnt     <= '0;
        pop_cnt    <= '0;
        wr_ptr     <= 1'b0;
        rd_ptr     <= 1'b0;
        fifo_count <= '0;
      end
    end
  end
endmodule
